// File: rtl/mdio_ctrl.sv
// mdio_ctrl: IEEE 802.3 clause-22 MDIO management master.
// Accepts one read/write request at a time and serializes a 64-bit frame:
// 32-bit preamble, ST/OP/PHYAD/REGAD, turnaround, then 16 data bits.
// Optional build macro: MDIO_TA_CHECK_EN (check that the PHY pulls TA bit 2 low).
// Ports:
//   Clk, Rstn              system clock, synchronous active-low reset
//   Req_Valid/Req_Ready    request handshake; Req_Wr, Req_Phy_Addr, Req_Reg_Addr, Req_Wdata
//   Rsp_Valid              one-cycle completion pulse with Rsp_Rdata, Rsp_Err
//   Busy                   frame in progress
//   Mdc                    management clock, period 2*CLK_DIV Clk cycles
//   Mdio_O/Mdio_Oe/Mdio_I  tri-state MDIO pad split
module mdio_ctrl #(
  parameter int unsigned CLK_DIV = 50
) (
  input  logic        Clk,
  input  logic        Rstn,
  input  logic        Req_Valid,
  output logic        Req_Ready,
  input  logic        Req_Wr,
  input  logic [4:0]  Req_Phy_Addr,
  input  logic [4:0]  Req_Reg_Addr,
  input  logic [15:0] Req_Wdata,
  output logic        Rsp_Valid,
  output logic [15:0] Rsp_Rdata,
  output logic        Rsp_Err,
  output logic        Busy,
  output logic        Mdc,
  output logic        Mdio_O,
  output logic        Mdio_Oe,
  input  logic        Mdio_I
);

  localparam int unsigned DIV_W     = 7;
  localparam int unsigned CNT_W     = 6;
  localparam int unsigned PRE_BITS  = 32;
  localparam int unsigned CMD_BITS  = 14;
  localparam int unsigned TA_BITS   = 2;
  localparam int unsigned DATA_BITS = 16;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_CMD, S_TA, S_DATA, S_DONE} state_t;

  logic [DIV_W-1:0]    div_cnt;
  logic                div_wrap, fall_tick, rise_tick;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                wr, wr_nxt;
  logic [CMD_BITS-1:0] cmd_sh, cmd_nxt;
  logic [15:0]         data_sh, data_nxt, rx_sh, rx_nxt, rdata_nxt;
  logic                o_nxt, oe_nxt, valid_nxt, ready_nxt, busy_nxt;

`ifdef MDIO_TA_CHECK_EN
  logic                ta_bad, ta_bad_nxt, err_nxt;
`endif

  // Free-running MDC divider; Mdc idles high out of reset
  assign div_wrap  = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign fall_tick = div_wrap & Mdc;
  assign rise_tick = div_wrap & ~Mdc;

  always_ff @(posedge Clk) begin
    if (!Rstn) begin
      div_cnt <= '0;
      Mdc     <= 1'b1;
    end else if (div_wrap) begin
      div_cnt <= '0;
      Mdc     <= ~Mdc;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // State and registered outputs
  always_ff @(posedge Clk) begin
    if (!Rstn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      wr        <= 1'b0;
      cmd_sh    <= '0;
      data_sh   <= '0;
      rx_sh     <= '0;
      Mdio_O    <= 1'b1;
      Mdio_Oe   <= 1'b0;
      Req_Ready <= 1'b0;
      Busy      <= 1'b0;
      Rsp_Valid <= 1'b0;
      Rsp_Rdata <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      wr        <= wr_nxt;
      cmd_sh    <= cmd_nxt;
      data_sh   <= data_nxt;
      rx_sh     <= rx_nxt;
      Mdio_O    <= o_nxt;
      Mdio_Oe   <= oe_nxt;
      Req_Ready <= ready_nxt;
      Busy      <= busy_nxt;
      Rsp_Valid <= valid_nxt;
      Rsp_Rdata <= rdata_nxt;
    end
  end

`ifdef MDIO_TA_CHECK_EN
  // Turnaround check result, reported with the completion pulse
  always_ff @(posedge Clk) begin
    if (!Rstn) begin
      ta_bad  <= 1'b0;
      Rsp_Err <= 1'b0;
    end else begin
      ta_bad  <= ta_bad_nxt;
      Rsp_Err <= err_nxt;
    end
  end
`else
  assign Rsp_Err = 1'b0;
`endif

  // Frame sequencer: state names the phase of the bit currently on the line;
  // cnt counts bits of that phase already driven. Bits change on fall_tick.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_nxt    = wr;
    cmd_nxt   = cmd_sh;
    data_nxt  = data_sh;
    rx_nxt    = rx_sh;
    o_nxt     = Mdio_O;
    oe_nxt    = Mdio_Oe;
    valid_nxt = 1'b0;
    rdata_nxt = Rsp_Rdata;
`ifdef MDIO_TA_CHECK_EN
    ta_bad_nxt = ta_bad;
    err_nxt    = Rsp_Err;
`endif
    unique case (state)
      S_IDLE: begin
        o_nxt  = 1'b1;
        oe_nxt = 1'b0;
        if (Req_Valid && Req_Ready) begin
          state_nxt = S_PRE;
          cnt_nxt   = '0;
          wr_nxt    = Req_Wr;
          cmd_nxt   = {2'b01, (Req_Wr ? 2'b01 : 2'b10), Req_Phy_Addr, Req_Reg_Addr};
          data_nxt  = Req_Wdata;
`ifdef MDIO_TA_CHECK_EN
          ta_bad_nxt = 1'b0;
`endif
        end
      end
      S_PRE: begin
        if (fall_tick) begin
          oe_nxt = 1'b1;
          if (cnt == CNT_W'(PRE_BITS)) begin
            state_nxt = S_CMD;
            o_nxt     = cmd_sh[CMD_BITS-1];
            cmd_nxt   = cmd_sh << 1;
            cnt_nxt   = CNT_W'(1);
          end else begin
            o_nxt   = 1'b1;
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      S_CMD: begin
        if (fall_tick) begin
          if (cnt == CNT_W'(CMD_BITS)) begin
            // Reads release the line for the whole turnaround
            state_nxt = S_TA;
            o_nxt     = 1'b1;
            oe_nxt    = wr;
            cnt_nxt   = CNT_W'(1);
          end else begin
            o_nxt   = cmd_sh[CMD_BITS-1];
            cmd_nxt = cmd_sh << 1;
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      S_TA: begin
        if (fall_tick) begin
          if (cnt == CNT_W'(TA_BITS)) begin
            state_nxt = S_DATA;
            o_nxt     = wr ? data_sh[15] : 1'b1;
            oe_nxt    = wr;
            data_nxt  = data_sh << 1;
            cnt_nxt   = CNT_W'(1);
          end else begin
            o_nxt   = ~wr;
            oe_nxt  = wr;
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
`ifdef MDIO_TA_CHECK_EN
        if (rise_tick && !wr && (cnt == CNT_W'(TA_BITS)))
          ta_bad_nxt = Mdio_I;
`endif
      end
      S_DATA: begin
        if (fall_tick && (cnt != CNT_W'(DATA_BITS))) begin
          o_nxt    = wr ? data_sh[15] : 1'b1;
          data_nxt = data_sh << 1;
          cnt_nxt  = cnt + CNT_W'(1);
        end
        if (rise_tick) begin
          rx_nxt = {rx_sh[14:0], Mdio_I};
          // Rise of the last data bit ends the frame
          if (cnt == CNT_W'(DATA_BITS)) begin
            state_nxt = S_DONE;
            valid_nxt = 1'b1;
            o_nxt     = 1'b1;
            oe_nxt    = 1'b0;
            if (!wr)
              rdata_nxt = {rx_sh[14:0], Mdio_I};
`ifdef MDIO_TA_CHECK_EN
            err_nxt = !wr && ta_bad;
`endif
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        o_nxt     = 1'b1;
        oe_nxt    = 1'b0;
      end
      default: state_nxt = S_IDLE;
    endcase
    ready_nxt = (state_nxt == S_IDLE);
    busy_nxt  = (state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_mdio_ctrl.sv
// tb_mdio_ctrl: self-checking bench for mdio_ctrl (CLK_DIV=4).
// A frame-level reference model builds the expected 64-bit MDIO sequence
// from the request fields; a small PHY model answers reads on Mdio_I.
module tb_mdio_ctrl;

`ifdef MDIO_TA_CHECK_EN
  localparam bit TA_CHK = 1'b1;
`else
  localparam bit TA_CHK = 1'b0;
`endif
  localparam int unsigned DIV = 4;

  logic        Clk, Rstn;
  logic        Req_Valid, Req_Ready, Req_Wr;
  logic [4:0]  Req_Phy_Addr, Req_Reg_Addr;
  logic [15:0] Req_Wdata, Rsp_Rdata;
  logic        Rsp_Valid, Rsp_Err, Busy, Mdc, Mdio_O, Mdio_Oe, Mdio_I;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] last_rdata = 16'h0000;

  mdio_ctrl #(.CLK_DIV(DIV)) dut (
    .Clk(Clk), .Rstn(Rstn),
    .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_Wr(Req_Wr),
    .Req_Phy_Addr(Req_Phy_Addr), .Req_Reg_Addr(Req_Reg_Addr), .Req_Wdata(Req_Wdata),
    .Rsp_Valid(Rsp_Valid), .Rsp_Rdata(Rsp_Rdata), .Rsp_Err(Rsp_Err), .Busy(Busy),
    .Mdc(Mdc), .Mdio_O(Mdio_O), .Mdio_Oe(Mdio_Oe), .Mdio_I(Mdio_I)
  );

  always #5 Clk = ~Clk;

  // Expected line values, first transmitted bit at [63]; read TA/DATA are don't-care
  function automatic logic [63:0] model_bits(input logic wr, input logic [4:0] phy,
                                             input logic [4:0] rega, input logic [15:0] wdata);
    return {32'hFFFF_FFFF, 2'b01, (wr ? 2'b01 : 2'b10), phy, rega,
            (wr ? 2'b10 : 2'b11), (wr ? wdata : 16'hFFFF)};
  endfunction

  function automatic logic [63:0] model_oe(input logic wr);
    return wr ? {64{1'b1}} : {{46{1'b1}}, {18{1'b0}}};
  endfunction

  // Issue one request and record Mdio_O/Mdio_Oe at every Mdc fall of the frame.
  // resp holds the PHY's TA (2 bits) then data, driven from the TA fall onward.
  task automatic do_frame(input logic wr, input logic [4:0] phy, input logic [4:0] rega,
                          input logic [15:0] wdata, input logic [17:0] resp,
                          output logic [63:0] obs_o, output logic [63:0] obs_oe,
                          output int n_valid, output logic [15:0] rdata, output logic err,
                          output int mdc_per, output bit tmo);
    int          k, cyc, last_rise, tail, guard;
    logic        prev_mdc;
    logic [17:0] resp_sh;
    obs_o = '0; obs_oe = '0; n_valid = 0; rdata = '0; err = 1'b0;
    mdc_per = 0; tmo = 1'b0; resp_sh = resp;
    Req_Wr = wr; Req_Phy_Addr = phy; Req_Reg_Addr = rega; Req_Wdata = wdata;
    Req_Valid = 1'b1;
    guard = 0;
    while (!Req_Ready && guard < 200) begin
      @(posedge Clk); #1; guard++;
    end
    if (!Req_Ready) begin
      Req_Valid = 1'b0;
      tmo = 1'b1;
      return;
    end
    @(posedge Clk); #1;
    Req_Valid = 1'b0;
    prev_mdc = Mdc; k = 0; cyc = 0; last_rise = -1; tail = 0;
    while (cyc < 2000 && tail < 4) begin
      @(posedge Clk); #1; cyc++;
      if (prev_mdc && !Mdc && k < 64) begin
        obs_o  = {obs_o[62:0], Mdio_O};
        obs_oe = {obs_oe[62:0], Mdio_Oe};
        if (k >= 46) begin
          Mdio_I  = resp_sh[17];
          resp_sh = resp_sh << 1;
        end else begin
          Mdio_I = 1'b1;
        end
        k++;
      end
      if (!prev_mdc && Mdc) begin
        if (last_rise >= 0) mdc_per = cyc - last_rise;
        last_rise = cyc;
      end
      if (Rsp_Valid) begin
        n_valid++;
        rdata = Rsp_Rdata;
        err   = Rsp_Err;
      end
      if (k == 64 && n_valid > 0) tail++;
      prev_mdc = Mdc;
    end
    Mdio_I = 1'b1;
    if (k < 64 || n_valid == 0) tmo = 1'b1;
  endtask

  task automatic test_reset();
    Rstn = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    checks++; if ({Req_Ready, Busy, Rsp_Valid, Rsp_Err, Mdio_Oe} !== 5'b00000) begin
      errors++; $display("FAIL reset_ctl: ready/busy/valid/err/oe got %b required 00000",
                         {Req_Ready, Busy, Rsp_Valid, Rsp_Err, Mdio_Oe});
    end
    checks++; if ({Mdc, Mdio_O} !== 2'b11) begin
      errors++; $display("FAIL reset_lines: mdc/mdio_o got %b required 11", {Mdc, Mdio_O});
    end
    checks++; if (Rsp_Rdata !== 16'h0000) begin
      errors++; $display("FAIL reset_rdata: got %h required 0000", Rsp_Rdata);
    end
    Rstn = 1'b1;
    @(posedge Clk); #1;
    checks++; if (Req_Ready !== 1'b1 || Busy !== 1'b0) begin
      errors++; $display("FAIL reset_release: ready %b busy %b required 1 0", Req_Ready, Busy);
    end
    last_rdata = 16'h0000;
  endtask

  task automatic test_write_vector();
    logic [63:0] oo, ooe, eo, eoe;
    logic [15:0] rd;
    logic        er;
    int          nv, per;
    bit          tmo;
    eo  = model_bits(1'b1, 5'h01, 5'h00, 16'h1140);
    eoe = model_oe(1'b1);
    do_frame(1'b1, 5'h01, 5'h00, 16'h1140, 18'h3FFFF, oo, ooe, nv, rd, er, per, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL wr_vec_timeout: frame did not complete"); end
    checks++; if (ooe !== eoe) begin
      errors++; $display("FAIL wr_vec_oe: got %h required %h", ooe, eoe);
    end
    checks++; if (oo !== eo) begin
      errors++; $display("FAIL wr_vec_bits: got %h required %h", oo, eo);
    end
    checks++; if (nv !== 1) begin errors++; $display("FAIL wr_vec_valid: got %0d pulses required 1", nv); end
    checks++; if (per !== 2 * DIV) begin
      errors++; $display("FAIL wr_vec_mdc_period: got %0d required %0d", per, 2 * DIV);
    end
    checks++; if (er !== 1'b0 || rd !== last_rdata) begin
      errors++; $display("FAIL wr_vec_rsp: err %b rdata %h required 0 %h", er, rd, last_rdata);
    end
  endtask

  task automatic test_read_vector();
    logic [17:0] cases [2];
    logic [63:0] oo, ooe, eo, eoe;
    logic [15:0] rd;
    logic        er, exp_err;
    int          nv, per;
    bit          tmo;
    cases[0] = {2'b10, 16'h0141};   // PHY pulls TA bit 2 low, returns 0x0141
    cases[1] = 18'h3FFFF;           // nobody drives: line pulled high
    for (int i = 0; i < 2; i++) begin
      eo  = model_bits(1'b0, 5'h1F, 5'h02, 16'h0000);
      eoe = model_oe(1'b0);
      exp_err = TA_CHK & cases[i][16];
      do_frame(1'b0, 5'h1F, 5'h02, 16'h0000, cases[i], oo, ooe, nv, rd, er, per, tmo);
      last_rdata = cases[i][15:0];
      checks++; if (tmo) begin errors++; $display("FAIL rd_vec%0d_timeout: frame did not complete", i); end
      checks++; if (ooe !== eoe) begin
        errors++; $display("FAIL rd_vec%0d_oe: got %h required %h", i, ooe, eoe);
      end
      checks++; if ((oo & eoe) !== (eo & eoe)) begin
        errors++; $display("FAIL rd_vec%0d_bits: got %h required %h", i, oo & eoe, eo & eoe);
      end
      checks++; if (nv !== 1 || rd !== last_rdata) begin
        errors++; $display("FAIL rd_vec%0d_data: pulses %0d rdata %h required 1 %h", i, nv, rd, last_rdata);
      end
      checks++; if (er !== exp_err) begin
        errors++; $display("FAIL rd_vec%0d_err: got %b required %b", i, er, exp_err);
      end
    end
  endtask

  task automatic test_hold_rdata();
    logic [63:0] oo, ooe;
    logic [15:0] rd;
    logic        er;
    int          nv, per;
    bit          tmo;
    do_frame(1'b0, 5'h03, 5'h11, 16'h0000, {2'b10, 16'hBEEF}, oo, ooe, nv, rd, er, per, tmo);
    last_rdata = 16'hBEEF;
    checks++; if (tmo || rd !== 16'hBEEF) begin
      errors++; $display("FAIL hold_read: tmo %b rdata %h required 0 beef", tmo, rd);
    end
    do_frame(1'b1, 5'h03, 5'h11, 16'h5A5A, 18'h3FFFF, oo, ooe, nv, rd, er, per, tmo);
    checks++; if (tmo || nv !== 1 || Rsp_Rdata !== last_rdata || er !== 1'b0) begin
      errors++; $display("FAIL hold_after_write: tmo %b pulses %0d rdata %h err %b required 0 1 %h 0",
                         tmo, nv, Rsp_Rdata, er, last_rdata);
    end
  endtask

  task automatic test_random();
    logic        wr, exp_err;
    logic [4:0]  phy, rega;
    logic [15:0] wd, rd;
    logic [17:0] resp;
    logic [63:0] oo, ooe, eo, eoe;
    logic        er;
    int          nv, per;
    bit          tmo;
    for (int i = 0; i < 10; i++) begin
      wr   = 1'($urandom_range(0, 1));
      phy  = 5'($urandom);
      rega = 5'($urandom);
      wd   = 16'($urandom);
      resp = 18'($urandom);
      eo   = model_bits(wr, phy, rega, wd);
      eoe  = model_oe(wr);
      exp_err = !wr && TA_CHK && resp[16];
      if (!wr) last_rdata = resp[15:0];
      do_frame(wr, phy, rega, wd, resp, oo, ooe, nv, rd, er, per, tmo);
      checks++; if (tmo || nv !== 1) begin
        errors++; $display("FAIL rnd%0d_complete: tmo %b pulses %0d required 0 1", i, tmo, nv);
      end
      checks++; if (ooe !== eoe || (oo & eoe) !== (eo & eoe)) begin
        errors++; $display("FAIL rnd%0d_line: wr %b oe %h bits %h required oe %h bits %h",
                           i, wr, ooe, oo & eoe, eoe, eo & eoe);
      end
      checks++; if (rd !== last_rdata || er !== exp_err) begin
        errors++; $display("FAIL rnd%0d_rsp: rdata %h err %b required %h %b", i, rd, er, last_rdata, exp_err);
      end
    end
  endtask

  task automatic test_back_to_back();
    int   cyc, accepts, n_valid, gap;
    logic prev_valid, hs, after_done;
    Req_Wr = 1'b1; Req_Phy_Addr = 5'h05; Req_Reg_Addr = 5'h09; Req_Wdata = 16'hA55A;
    Req_Valid = 1'b1;
    cyc = 0; accepts = 0; n_valid = 0; gap = 0; prev_valid = 1'b0; after_done = 1'b0;
    while (cyc < 3000 && n_valid < 2) begin
      hs = Req_Valid && Req_Ready;
      if (hs) begin
        accepts++;
        if (accepts == 2) after_done = prev_valid;
      end
      prev_valid = Rsp_Valid;
      @(posedge Clk); #1; cyc++;
      if (hs && accepts == 1) begin
        Req_Phy_Addr = 5'h06; Req_Wdata = 16'h0FF0;
      end
      if (hs && accepts == 2) Req_Valid = 1'b0;
      if (Rsp_Valid) n_valid++;
      if (n_valid == 1 && !Busy) gap++;
    end
    Req_Valid = 1'b0;
    checks++; if (n_valid !== 2 || accepts !== 2) begin
      errors++; $display("FAIL b2b_count: pulses %0d accepts %0d required 2 2", n_valid, accepts);
    end
    checks++; if (after_done !== 1'b1) begin
      errors++; $display("FAIL b2b_accept_timing: prior-cycle valid %b required 1", after_done);
    end
    checks++; if (gap !== 1) begin
      errors++; $display("FAIL b2b_busy_gap: got %0d cycles required 1", gap);
    end
  endtask

  task automatic test_reset_mid_frame();
    int   k, cyc, n_valid;
    logic prev_mdc;
    Req_Wr = 1'b0; Req_Phy_Addr = 5'h12; Req_Reg_Addr = 5'h07; Req_Valid = 1'b1;
    cyc = 0;
    while (!Req_Ready && cyc < 200) begin @(posedge Clk); #1; cyc++; end
    @(posedge Clk); #1;
    Req_Valid = 1'b0;
    prev_mdc = Mdc; k = 0; cyc = 0;
    // stop once CMD bit 5 (overall bit 37) is on the line
    while (k < 38 && cyc < 2000) begin
      @(posedge Clk); #1; cyc++;
      if (prev_mdc && !Mdc) k++;
      prev_mdc = Mdc;
    end
    checks++; if (k !== 38 || Mdio_Oe !== 1'b1 || Busy !== 1'b1) begin
      errors++; $display("FAIL rst_mid_setup: falls %0d oe %b busy %b required 38 1 1", k, Mdio_Oe, Busy);
    end
    Rstn = 1'b0;
    @(posedge Clk); #1;
    checks++; if ({Mdio_Oe, Mdio_O, Busy, Req_Ready, Mdc} !== 5'b01001) begin
      errors++; $display("FAIL rst_mid_release: oe/o/busy/ready/mdc got %b required 01001",
                         {Mdio_Oe, Mdio_O, Busy, Req_Ready, Mdc});
    end
    n_valid = 0;
    repeat (2) begin @(posedge Clk); #1; if (Rsp_Valid) n_valid++; end
    Rstn = 1'b1;
    last_rdata = 16'h0000;
    @(posedge Clk); #1;
    if (Rsp_Valid) n_valid++;
    checks++; if (Req_Ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_ready: got %b required 1", Req_Ready);
    end
    repeat (600) begin @(posedge Clk); #1; if (Rsp_Valid) n_valid++; end
    checks++; if (n_valid !== 0 || Busy !== 1'b0 || Rsp_Rdata !== last_rdata) begin
      errors++; $display("FAIL rst_mid_quiet: pulses %0d busy %b rdata %h required 0 0 %h",
                         n_valid, Busy, Rsp_Rdata, last_rdata);
    end
  endtask

  initial begin
    Clk = 1'b0; Rstn = 1'b0; Req_Valid = 1'b0; Req_Wr = 1'b0;
    Req_Phy_Addr = '0; Req_Reg_Addr = '0; Req_Wdata = '0; Mdio_I = 1'b1;
    test_reset();
    test_write_vector();
    test_read_vector();
    test_hold_rdata();
    test_random();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
